// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle mini-MIPS controller (states, opcodes, mux selects, trap causes).
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IOP   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic is_itype_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_SLTIU) ||
               (op == OP_ANDI) || (op == OP_ORI)  || (op == OP_XORI)  ||
               (op == OP_LUI);
    endfunction

    // States that wait on mem_ready and are therefore covered by the wait timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: controller <-> datapath/memory bundle: run/opcode/zero/mem_ready in, strobes, mux selects and status out.
// Latency: n/a (wiring only).
// Backpressure: mem_ready is the only stall input; the controller holds its memory strobes until it is seen.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             ir_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic [3:0]       state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    // Controller side
    modport master (
        input  run, opcode, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               state, trap, trap_cause, retired
    );

    // Datapath / memory side
    modport slave (
        output run, opcode, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               state, trap, trap_cause, retired
    );
endinterface

// File: rtl/mips_mem_wait_timer.sv
// Purpose: counts consecutive cycles spent waiting on mem_ready; flags the cycle that would exceed the limit.
// Latency: timeout is combinational from the current count and the waiting input.
// Backpressure: n/a; clr has priority over counting. Ports: clk, rst_n, clr, waiting in; timeout out.
module mips_mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic waiting,
    output logic timeout
);
    // Count only needs to reach TIMEOUT_CYCLES-1: the next waiting cycle traps.
    localparam int CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (waiting) begin
            count_q <= count_q + CW'(1);
        end
    end

    // A limit of zero disables the timeout entirely; the counter then wraps harmlessly.
    assign timeout = (TIMEOUT_CYCLES != 0) && waiting && (count_q == LAST);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: multi-cycle mini-MIPS sequencer: steps fetch/decode/execute/memory/writeback, traps on illegal op or memory timeout.
// Latency: one state per cycle; memory states stall until mem_ready or until the wait timer expires.
// Backpressure: memory strobes held while mem_ready=0. Ports: clk, rst_n, bus (mips_multicycle_ctrl_if.master).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       cause_q;
    logic [1:0]       cause_d;
    logic [CNT_W-1:0] retired_q;

    logic waiting;
    logic timer_clr;
    logic timeout;
    logic instr_end;
    logic take_branch;

    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;

    assign waiting     = is_wait_state(state_q) && !bus.mem_ready;
    // Clear on entry only, so back-to-back wait states (e.g. MEM_WR -> FETCH) restart the count.
    assign timer_clr   = is_wait_state(state_d) && (state_d != state_q);
    assign take_branch = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                         ((bus.opcode == OP_BNE) && !bus.zero);

    mips_mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .waiting(waiting),
        .timeout(timeout)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        instr_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.opcode == OP_RTYPE) begin
                    state_d = S_EXEC_R;
                end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
                    state_d = S_MEM_ADDR;
                end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
                    state_d = S_BRANCH;
                end else if (bus.opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (is_itype_alu(bus.opcode)) begin
                    state_d = S_EXEC_I;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_MEM_ADDR: begin
                // opcode is stable, so anything but lw/sw here means IR was corrupted.
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_MEM_RD: begin
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WR: begin
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    instr_end = 1'b1;
                end
            end
            S_MEM_WB: instr_end = 1'b1;
            S_EXEC_R: state_d   = S_R_WB;
            S_R_WB:   instr_end = 1'b1;
            S_EXEC_I: state_d   = S_I_WB;
            S_I_WB:   instr_end = 1'b1;
            S_BRANCH: instr_end = 1'b1;
            S_JUMP:   instr_end = 1'b1;
            S_TRAP:   state_d   = S_TRAP;
            default:  state_d   = S_IDLE;
        endcase
        // run is only consulted at instruction boundaries, never mid-instruction.
        if (instr_end) state_d = bus.run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (instr_end) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Moore decode of the state register; only FETCH writes (mem_ready) and BRANCH pc_write are qualified.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                // On the timeout cycle nothing is requested; the FSM heads to TRAP.
                mem_read  = !timeout;
                alu_src_b = SRCB_FOUR;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = !timeout;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = !timeout;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_IOP;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = take_branch;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_write   = pc_write;
    assign bus.ir_write   = ir_write;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_src     = pc_src;
    assign bus.state      = state_q;
    assign bus.trap       = (state_q == S_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: directed bench for mips_multicycle_ctrl: instruction sequences, stalls, traps, timeout and reset.
// Latency: checks taken 3 time units after each rising edge, once outputs have settled.
// Backpressure: mem_ready driven directly by the stimulus to create stalls and timeouts.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();

    mips_multicycle_ctrl #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Strobe vector: pc_write ir_write iord mem_read mem_write reg_write reg_dst mem_to_reg alu_src_a alu_src_b[2] alu_op[2] pc_src[2]
    localparam logic [14:0] V_ZERO    = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] V_FETCH_R = 15'b1_1_0_1_0_0_0_0_0_01_00_00;
    localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [14:0] V_EXEC_R  = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [14:0] V_R_WB    = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
    localparam logic [14:0] V_MEMADDR = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] V_MEM_RD  = 15'b0_0_1_1_0_0_0_0_0_00_00_00;
    localparam logic [14:0] V_MEM_WB  = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [14:0] V_MEM_WR  = 15'b0_0_1_0_1_0_0_0_0_00_00_00;
    localparam logic [14:0] V_EXEC_I  = 15'b0_0_0_0_0_0_0_0_1_10_11_00;
    localparam logic [14:0] V_I_WB    = 15'b0_0_0_0_0_1_0_0_0_00_00_00;
    localparam logic [14:0] V_BR_T    = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] V_BR_N    = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] V_JUMP    = 15'b1_0_0_0_0_0_0_0_0_00_00_10;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] strb();
        return {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp_st);
        chk(tag, 32'(bus.state), 32'(exp_st));
    endtask

    task automatic chk_sv(input string tag, input logic [14:0] exp_v);
        chk(tag, 32'(strb()), 32'(exp_v));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.run       = 1'b0;
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #3;
        chk_st("rst_state", 4'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_cause", 32'(bus.trap_cause), 32'd0);
        chk("rst_trap", 32'(bus.trap), 32'd0);
        chk_sv("rst_strobes", V_ZERO);
        #15;
        rst_n         = 1'b1;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;

        // R-type, memory always ready
        tick(); settle(); chk_st("r_fetch", 4'd1);  chk_sv("r_fetch_v", V_FETCH_R);
        tick(); settle(); chk_st("r_decode", 4'd2); chk_sv("r_decode_v", V_DECODE);
        tick(); settle(); chk_st("r_exec", 4'd7);   chk_sv("r_exec_v", V_EXEC_R);
        tick(); settle(); chk_st("r_wb", 4'd8);     chk_sv("r_wb_v", V_R_WB);
        chk("r_wb_retired", bus.retired, 32'd0);
        tick(); settle(); chk_st("r_refetch", 4'd1);
        chk("r_retired", bus.retired, 32'd1);

        // lw with three stall cycles in MEM_RD
        bus.opcode = 6'b100011;
        tick(); settle(); chk_st("lw_decode", 4'd2);
        tick(); settle(); chk_st("lw_addr", 4'd3); chk_sv("lw_addr_v", V_MEMADDR);
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            settle();
            chk_st("lw_memrd", 4'd4);
            chk_sv("lw_memrd_v", V_MEM_RD);
            tick();
        end
        settle(); chk_st("lw_wb", 4'd5); chk_sv("lw_wb_v", V_MEM_WB);
        chk("lw_wb_retired", bus.retired, 32'd1);
        tick(); settle(); chk_st("lw_refetch", 4'd1);
        chk("lw_retired", bus.retired, 32'd2);

        // beq taken, bne not taken (zero=1 for both)
        bus.opcode = 6'b000100;
        bus.zero   = 1'b1;
        tick(); tick(); settle(); chk_st("beq_st", 4'd11); chk_sv("beq_v", V_BR_T);
        tick(); settle(); chk_st("beq_next", 4'd1);
        chk("beq_retired", bus.retired, 32'd3);
        bus.opcode = 6'b000101;
        tick(); tick(); settle(); chk_st("bne_st", 4'd11); chk_sv("bne_v", V_BR_N);
        tick(); settle(); chk_st("bne_next", 4'd1);
        chk("bne_retired", bus.retired, 32'd4);

        // sw with immediate ready, then j
        bus.opcode = 6'b101011;
        tick(); tick(); settle(); chk_st("sw_addr", 4'd3);
        tick(); settle(); chk_st("sw_memwr", 4'd6); chk_sv("sw_memwr_v", V_MEM_WR);
        tick(); settle(); chk_st("sw_next", 4'd1);
        chk("sw_retired", bus.retired, 32'd5);
        bus.opcode = 6'b000010;
        tick(); tick(); settle(); chk_st("j_st", 4'd12); chk_sv("j_v", V_JUMP);
        tick(); settle(); chk_st("j_next", 4'd1);
        chk("j_retired", bus.retired, 32'd6);

        // addi with run dropped during EXEC_I
        bus.opcode = 6'b001000;
        tick(); tick(); settle(); chk_st("addi_exec", 4'd9); chk_sv("addi_exec_v", V_EXEC_I);
        bus.run = 1'b0;
        tick(); settle(); chk_st("addi_wb", 4'd10); chk_sv("addi_wb_v", V_I_WB);
        tick(); settle(); chk_st("addi_idle", 4'd0); chk_sv("addi_idle_v", V_ZERO);
        chk("addi_retired", bus.retired, 32'd7);
        tick(); settle(); chk_st("idle_hold", 4'd0);

        // mem_ready arrives on the 16th FETCH cycle: normal DECODE, then illegal opcode trap
        bus.mem_ready = 1'b0;
        bus.run       = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) begin
                bus.mem_ready = 1'b1;
                bus.opcode    = 6'b111111;
            end
            settle();
            chk_st("lim_fetch", 4'd1);
            if (c == 16) chk_sv("lim_fetch_v", V_FETCH_R);
            tick();
        end
        settle(); chk_st("lim_decode", 4'd2);
        tick(); settle();
        chk_st("ill_state", 4'd15);
        chk("ill_trap", 32'(bus.trap), 32'd1);
        chk("ill_cause", 32'(bus.trap_cause), 32'd1);
        chk_sv("ill_strobes", V_ZERO);
        for (int k = 0; k < 3; k++) begin
            bus.run = ~bus.run;
            tick(); settle();
            chk_st("ill_hold", 4'd15);
        end
        chk("ill_retired_frozen", bus.retired, 32'd7);
        rst_n = 1'b0;
        #1;
        chk_st("ill_rst_state", 4'd0);
        chk("ill_rst_cause", 32'(bus.trap_cause), 32'd0);
        chk("ill_rst_retired", bus.retired, 32'd0);
        #4;
        rst_n         = 1'b1;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'b000000;

        // FETCH timeout after 16 unanswered cycles
        tick();
        for (int c = 1; c <= 16; c++) begin
            settle();
            chk_st("to_fetch", 4'd1);
            tick();
        end
        settle();
        chk_st("to_state", 4'd15);
        chk("to_trap", 32'(bus.trap), 32'd1);
        chk("to_cause", 32'(bus.trap_cause), 32'd2);
        chk_sv("to_strobes", V_ZERO);
        rst_n = 1'b0;
        #1;
        chk_st("to_rst_state", 4'd0);
        #4;
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;

        // Reset asserted in the middle of a stalled MEM_WR
        tick(); tick(); tick(); tick(); tick();
        settle(); chk("pre_sw_retired", bus.retired, 32'd1);
        bus.opcode = 6'b101011;
        tick(); tick();
        bus.mem_ready = 1'b0;
        tick(); settle();
        chk_st("rwr_state", 4'd6);
        chk("rwr_memwrite", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_st("rwr_rst_state", 4'd0);
        chk("rwr_rst_memwrite", 32'(bus.mem_write), 32'd0);
        chk("rwr_rst_retired", bus.retired, 32'd0);
        #4;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencing controller for the mini-MIPS datapath. It replaces the single-cycle opcode decoder with an FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives per-cycle mux/enable strobes to PC, IR, register file, ALU and the shared instruction/data memory port, and handshakes with memory via mem_ready. It also bounds memory wait time and traps on illegal opcodes or memory timeouts.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting for mem_ready in any memory state; 0 disables the timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
run  in  1  1 = keep issuing instructions; sampled only in IDLE and at instruction end
opcode  in  6  IR[31:26]; stable from DECODE until instruction end
zero  in  1  ALU zero flag, valid in BRANCH
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC load enable
ir_write  out  1  IR load enable
iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = R-type funct, 11 = I-type op from opcode
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  out  4  current state encoding, for debug
trap  out  1  high while in TRAP
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout; sticky until reset
retired  out  CNT_W  completed-instruction count; wraps modulo 2^CNT_W

Behaviour:
- Reset: async on rst_n=0. State goes to IDLE (0). retired=0, trap_cause=00, wait timer=0. All strobes 0 and all mux selects 0 while in IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, EXEC_I=9, I_WB=10, BRANCH=11, JUMP=12, TRAP=15.
- Outputs are Moore from state. Exceptions: ir_write and pc_write in FETCH are qualified by mem_ready; pc_write in BRANCH is qualified by the condition.
- IDLE: go to FETCH if run=1.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000, 001010, 001011, 001100, 001101, 001110, 001111 -> EXEC_I
  - anything else -> TRAP, cause 01
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD for lw (100011), MEM_WR for sw (101011).
- MEM_RD: iord=1, mem_read=1; on mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEM_WR: iord=1, mem_write=1; the instruction ends on mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11 -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write=1 if (opcode=000100 and zero=1) or (opcode=000101 and zero=0).
- JUMP: pc_src=10, pc_write=1.
- Instruction end (leaving MEM_WB, MEM_WR on ready, R_WB, I_WB, BRANCH, JUMP): retired+1; next state is FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction never aborts the instruction.
- Wait timer: clears on entry to FETCH, MEM_RD or MEM_WR; increments each cycle in those states with mem_ready=0.
  - If timer = TIMEOUT_CYCLES-1 and mem_ready=0: next state TRAP, cause 10, and no strobe is issued that cycle.
  - If mem_ready arrives on the limit cycle, the access completes normally.
- TRAP: all strobes 0, trap=1. Only reset exits TRAP. retired is frozen.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - alu_op, alu_src_b and pc_src encodings
  - trap_cause codes
- Sub-module mips_mem_wait_timer: clear/enable/limit counter with a timeout pulse output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset then run=1, opcode=000000, mem_ready=1 always -> states 1,2,7,8,1. ir_write and pc_write high in FETCH; reg_write=1 with reg_dst=1 in R_WB; retired=1 after 4 cycles.
- lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read/iord held for 4 cycles, then MEM_WB with mem_to_reg=1; retired increments once.
- beq with zero=1 -> pc_write=1 and pc_src=01 in BRANCH. bne with zero=1 -> pc_write=0. Both return to FETCH.
- opcode=111111 in DECODE -> TRAP next cycle, trap=1, cause=01, all strobes 0. Held until rst_n low; run toggling has no effect.
- TIMEOUT_CYCLES=16, mem_ready=0 in FETCH -> TRAP with cause 10 after 16 FETCH cycles. Repeat with mem_ready on cycle 16 -> normal DECODE.
- run dropped during EXEC_I -> I_WB completes, retired+1, then IDLE. rst_n pulsed low mid-MEM_WR -> immediate IDLE, mem_write=0, retired=0.
